// File: rtl/strobe_seq38_if.sv
// strobe_seq38_if: request handshake and decoder-drive signals of strobe_seq38.
// Mask mode (STROBE_SEQ_MASK_EN defined) swaps the 3-bit req_idx for an 8-bit req_mask.
interface strobe_seq38_if;
    logic       req_valid;
`ifdef STROBE_SEQ_MASK_EN
    logic [7:0] req_mask;
`else
    logic [2:0] req_idx;
`endif
    logic       req_ready;
    logic       sel_a;
    logic       sel_b;
    logic       sel_c;
    logic       sel_g;
    logic       busy;
    logic       done;

`ifdef STROBE_SEQ_MASK_EN
    modport master (output req_valid, output req_mask, input req_ready,
                    input sel_a, input sel_b, input sel_c, input sel_g,
                    input busy, input done);
    modport slave  (input req_valid, input req_mask, output req_ready,
                    output sel_a, output sel_b, output sel_c, output sel_g,
                    output busy, output done);
`else
    modport master (output req_valid, output req_idx, input req_ready,
                    input sel_a, input sel_b, input sel_c, input sel_g,
                    input busy, input done);
    modport slave  (input req_valid, input req_idx, output req_ready,
                    output sel_a, output sel_b, output sel_c, output sel_g,
                    output busy, output done);
`endif
endinterface

// File: rtl/strobe_seq38.sv
// strobe_seq38: queued strobe sequencer feeding a 3-to-8 active-low-enable decoder.
// Each request becomes a SETUP / PULSE / HOLD envelope on sel_a/b/c and sel_g so the
// decoder output fires one clean pulse. Index bits only move while sel_g is high.
// Optional build macro STROBE_SEQ_MASK_EN: requests carry an 8-bit mask and one
// envelope is emitted per set bit, lowest bit first, with a single done at the end.
module strobe_seq38 #(
    parameter int SETUP_LEN = 1,
    parameter int PULSE_LEN = 2,
    parameter int HOLD_LEN  = 1
) (
    input  logic          sys_clk,
    input  logic          reset,
    strobe_seq38_if.slave bus
);

    // Phase lengths must fit the 4-bit phase counter and be non-zero.
    if (SETUP_LEN < 1 || SETUP_LEN > 15) begin : g_bad_setup_len
        $error("strobe_seq38: SETUP_LEN must be in 1..15");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse_len
        $error("strobe_seq38: PULSE_LEN must be in 1..15");
    end
    if (HOLD_LEN < 1 || HOLD_LEN > 15) begin : g_bad_hold_len
        $error("strobe_seq38: HOLD_LEN must be in 1..15");
    end

    localparam logic [3:0] SETUP_M1 = 4'(SETUP_LEN - 1);
    localparam logic [3:0] PULSE_M1 = 4'(PULSE_LEN - 1);
    localparam logic [3:0] HOLD_M1  = 4'(HOLD_LEN - 1);

`ifdef STROBE_SEQ_MASK_EN
    localparam int EW = 8;

    // Index of the lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction
`else
    localparam int EW = 3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Two-entry request queue.
    logic [EW-1:0] fifo_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic [EW-1:0] in_s;
    logic [EW-1:0] head_s;
    logic          push_s;
    logic          pop_s;

    // Sequencer state and registered outputs.
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          g_q, g_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
`ifdef STROBE_SEQ_MASK_EN
    logic [7:0]    rem_q, rem_d;

    assign in_s = bus.req_mask;
`else
    assign in_s = bus.req_idx;
`endif

    // A full queue refuses pushes even when a pop happens in the same cycle,
    // because acceptance is decided from the registered count alone.
    assign push_s  = bus.req_valid & ready_q;
    assign head_s  = fifo_q[rd_ptr_q];
    assign count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};

    // Queue storage, pointers and occupancy.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= in_s;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Envelope sequencing: next state, phase counter, index load and queue pop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pop_s   = 1'b0;
`ifdef STROBE_SEQ_MASK_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (count_q != 2'd0) begin
                    pop_s = 1'b1;
`ifdef STROBE_SEQ_MASK_EN
                    if (head_s != 8'd0) begin
                        sel_d   = lowest_bit(head_s);
                        rem_d   = head_s & (head_s - 8'd1);
                        cnt_d   = SETUP_M1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    sel_d   = head_s;
                    cnt_d   = SETUP_M1;
                    state_d = ST_SETUP;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = PULSE_M1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = HOLD_M1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
`ifdef STROBE_SEQ_MASK_EN
                end else if (rem_q != 8'd0) begin
                    sel_d   = lowest_bit(rem_q);
                    rem_d   = rem_q & (rem_q - 8'd1);
                    cnt_d   = SETUP_M1;
                    state_d = ST_SETUP;
                end else if (count_q != 2'd0 && head_s != 8'd0) begin
                    pop_s   = 1'b1;
                    sel_d   = lowest_bit(head_s);
                    rem_d   = head_s & (head_s - 8'd1);
                    cnt_d   = SETUP_M1;
                    state_d = ST_SETUP;
`else
                end else if (count_q != 2'd0) begin
                    pop_s   = 1'b1;
                    sel_d   = head_s;
                    cnt_d   = SETUP_M1;
                    state_d = ST_SETUP;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase

        // done marks the final HOLD cycle of a request, so it is set on entry to it.
`ifdef STROBE_SEQ_MASK_EN
        done_d  = (state_d == ST_HOLD) && (cnt_d == 4'd0) && (rem_d == 8'd0);
`else
        done_d  = (state_d == ST_HOLD) && (cnt_d == 4'd0);
`endif
        g_d     = (state_d != ST_PULSE);
        busy_d  = (state_d != ST_IDLE) || (count_d != 2'd0);
        ready_d = (count_d < 2'd2);
    end

    // State, counter and output registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            g_q     <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef STROBE_SEQ_MASK_EN
            rem_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            g_q     <= g_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef STROBE_SEQ_MASK_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.sel_a     = sel_q[0];
    assign bus.sel_b     = sel_q[1];
    assign bus.sel_c     = sel_q[2];
    assign bus.sel_g     = g_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_strobe_seq38.sv
// tb_strobe_seq38: directed and random checks of strobe_seq38 against a
// request-level model (accepted index list, envelope lengths from the parameters).
module tb_strobe_seq38;

    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int S2 = 3;
    localparam int P2 = 4;
    localparam int H2 = 2;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    strobe_seq38_if u_if ();
    strobe_seq38_if u_if2 ();

    strobe_seq38 #(.SETUP_LEN(S), .PULSE_LEN(P), .HOLD_LEN(H)) u_dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (u_if)
    );

    strobe_seq38 #(.SETUP_LEN(S2), .PULSE_LEN(P2), .HOLD_LEN(H2)) u_dut2 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (u_if2)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse monitor state for u_dut.
    int   got_idx [$];
    int   got_w   [$];
    int   gap_q   [$];
    int   n_done   = 0;
    int   w_cnt    = 0;
    int   hi_run   = 0;
    logic prev_g   = 1'b1;
    logic [2:0] pulse_sel = 3'd0;
    logic sel_moved = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] item(input int idx);
`ifdef STROBE_SEQ_MASK_EN
        return 8'(32'd1 << idx);
`else
        return 8'(idx);
`endif
    endfunction

    task automatic drive(input logic v, input logic [7:0] d);
        u_if.req_valid = v;
`ifdef STROBE_SEQ_MASK_EN
        u_if.req_mask = d;
`else
        u_if.req_idx = d[2:0];
`endif
    endtask

    task automatic drive2(input logic v, input logic [7:0] d);
        u_if2.req_valid = v;
`ifdef STROBE_SEQ_MASK_EN
        u_if2.req_mask = d;
`else
        u_if2.req_idx = d[2:0];
`endif
    endtask

    // Advance to the next falling edge and update the pulse monitor.
    task automatic cyc();
        logic [2:0] cur;
        @(negedge sys_clk);
        cur = {u_if.sel_c, u_if.sel_b, u_if.sel_a};
        if (u_if.sel_g === 1'b0) begin
            if (prev_g) begin
                got_idx.push_back(int'(cur));
                gap_q.push_back(hi_run);
                pulse_sel = cur;
                w_cnt     = 1;
            end else begin
                w_cnt++;
                if (cur !== pulse_sel) sel_moved = 1'b1;
            end
        end else begin
            if (!prev_g) begin
                got_w.push_back(w_cnt);
                hi_run = 0;
            end
            hi_run++;
        end
        if (u_if.done === 1'b1) n_done++;
        prev_g = u_if.sel_g;
    endtask

    task automatic clear_mon();
        got_idx.delete();
        got_w.delete();
        gap_q.delete();
    endtask

    task automatic drain();
        int guard = 0;
        while ((u_if.busy !== 1'b0 || u_if.sel_g !== 1'b1) && guard < 300) begin
            cyc();
            guard++;
        end
        chk("drain_busy", 32'(u_if.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int d0;
        int exp_idx [$];
        int exp_done;
        int exp_w;
        int exp_g;
        logic [7:0] r;

        drive(1'b0, 8'd0);
        drive2(1'b0, 8'd0);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state.
        chk("rst_sel",   32'({u_if.sel_c, u_if.sel_b, u_if.sel_a}), 32'd0);
        chk("rst_g",     32'(u_if.sel_g), 32'd1);
        chk("rst_done",  32'(u_if.done), 32'd0);
        chk("rst_busy",  32'(u_if.busy), 32'd0);
        chk("rst_ready", 32'(u_if.req_ready), 32'd1);

        // Single request, index 5, default envelope.
        d0 = n_done;
        drive(1'b1, item(5));
        cyc();
        drive(1'b0, 8'd0);
        chk("t1_c0_busy", 32'(u_if.busy), 32'd1);
        chk("t1_c0_g", 32'(u_if.sel_g), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            exp_g = (k >= 1 + S && k <= S + P) ? 0 : 1;
            chk("t1_sel",  32'({u_if.sel_c, u_if.sel_b, u_if.sel_a}), 32'd5);
            chk("t1_g",    32'(u_if.sel_g), 32'(exp_g));
            chk("t1_done", 32'(u_if.done), (k == S + P + H) ? 32'd1 : 32'd0);
            chk("t1_busy", 32'(u_if.busy), (k <= S + P + H) ? 32'd1 : 32'd0);
        end
        chk("t1_ndone", 32'(n_done - d0), 32'd1);

        // Long envelope on the second instance, index 7.
        drive2(1'b1, item(7));
        cyc();
        drive2(1'b0, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            exp_g = (k >= 1 + S2 && k <= S2 + P2) ? 0 : 1;
            chk("t3_g",    32'(u_if2.sel_g), 32'(exp_g));
            chk("t3_done", 32'(u_if2.done), (k == S2 + P2 + H2) ? 32'd1 : 32'd0);
            if (k == 1 + S2) chk("t3_sel", 32'({u_if2.sel_c, u_if2.sel_b, u_if2.sel_a}), 32'd7);
        end

        // Back-to-back requests 3, 6, 1, 2 with a full queue holding off the last.
        clear_mon();
        d0 = n_done;
        drive(1'b1, item(3));
        cyc();
        drive(1'b1, item(6));
        cyc();
        drive(1'b1, item(1));
        cyc();
        chk("t2_ready_full", 32'(u_if.req_ready), 32'd0);
        drive(1'b1, item(2));
        waits = 0;
        while (u_if.req_ready !== 1'b1 && waits < 20) begin
            cyc();
            waits++;
        end
        chk("t2_waits", 32'(waits), 32'd3);
        cyc();
        drive(1'b0, 8'd0);
        drain();
        chk("t2_npulse", 32'(got_idx.size()), 32'd4);
        if (got_idx.size() == 4) begin
            chk("t2_idx0", 32'(got_idx[0]), 32'd3);
            chk("t2_idx1", 32'(got_idx[1]), 32'd6);
            chk("t2_idx2", 32'(got_idx[2]), 32'd1);
            chk("t2_idx3", 32'(got_idx[3]), 32'd2);
            for (int i = 1; i < 4; i++) chk("t2_gap", 32'(gap_q[i]), 32'(H + S));
        end
        foreach (got_w[i]) chk("t2_width", 32'(got_w[i]), 32'(P));
        chk("t2_ndone", 32'(n_done - d0), 32'd4);
        chk("t2_sel_frozen", 32'(sel_moved), 32'd0);

        // Reset during the second PULSE cycle with one request still queued.
        drive(1'b1, item(4));
        cyc();
        drive(1'b1, item(2));
        cyc();
        drive(1'b0, 8'd0);
        cyc();
        chk("t4_pulse1", 32'(u_if.sel_g), 32'd0);
        cyc();
        chk("t4_pulse2", 32'(u_if.sel_g), 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t4_g",     32'(u_if.sel_g), 32'd1);
        chk("t4_busy",  32'(u_if.busy), 32'd0);
        chk("t4_ready", 32'(u_if.req_ready), 32'd1);
        chk("t4_done",  32'(u_if.done), 32'd0);
        clear_mon();
        d0 = n_done;
        for (int k = 0; k < 12; k++) cyc();
        chk("t4_no_strobe", 32'(got_idx.size()), 32'd0);
        chk("t4_no_done", 32'(n_done - d0), 32'd0);

`ifdef STROBE_SEQ_MASK_EN
        // Mask 0x82 gives strobes on 1 then 7 with a single done; mask 0 does nothing.
        clear_mon();
        d0 = n_done;
        drive(1'b1, 8'h82);
        cyc();
        drive(1'b0, 8'd0);
        drain();
        chk("m_npulse", 32'(got_idx.size()), 32'd2);
        if (got_idx.size() == 2) begin
            chk("m_idx0", 32'(got_idx[0]), 32'd1);
            chk("m_idx1", 32'(got_idx[1]), 32'd7);
        end
        chk("m_ndone", 32'(n_done - d0), 32'd1);
        clear_mon();
        d0 = n_done;
        drive(1'b1, 8'h00);
        cyc();
        drive(1'b0, 8'd0);
        for (int k = 0; k < 6; k++) cyc();
        chk("m0_npulse", 32'(got_idx.size()), 32'd0);
        chk("m0_ndone", 32'(n_done - d0), 32'd0);
`endif

        // Random traffic: every accepted request strobed once, in order, exact width.
        clear_mon();
        sel_moved = 1'b0;
        d0 = n_done;
        exp_done = 0;
        for (int c = 0; c < 10000; c++) begin
            r = 8'($urandom_range(0, 255));
`ifndef STROBE_SEQ_MASK_EN
            r = {5'd0, r[2:0]};
`endif
            drive(1'($urandom_range(0, 1)), r);
            if (u_if.req_valid && u_if.req_ready === 1'b1) begin
`ifdef STROBE_SEQ_MASK_EN
                for (int b = 0; b < 8; b++) if (r[b]) exp_idx.push_back(b);
                if (r != 8'd0) exp_done++;
`else
                exp_idx.push_back(int'(r));
                exp_done++;
`endif
            end
            cyc();
        end
        drive(1'b0, 8'd0);
        drain();
        chk("rnd_count", 32'(got_idx.size()), 32'(exp_idx.size()));
        if (got_idx.size() == exp_idx.size()) begin
            foreach (exp_idx[i]) chk("rnd_idx", 32'(got_idx[i]), 32'(exp_idx[i]));
        end
        exp_w = P;
        foreach (got_w[i]) chk("rnd_width", 32'(got_w[i]), 32'(exp_w));
        chk("rnd_ndone", 32'(n_done - d0), 32'(exp_done));
        chk("rnd_sel_frozen", 32'(sel_moved), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
